// File: rtl/icache_pkg.sv
// Shared types and address-split constants for the direct-mapped instruction cache.
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FILL  = 2'd2
    } state_t;

    localparam int ADDR_W    = 32;
    localparam int WORD_W    = 32;
    localparam int LINE_W    = 256;
    localparam int WORDS     = LINE_W / WORD_W;
    localparam int OFFSET_W  = 5;
    localparam int WSEL_W    = 3;
    localparam int DEF_LINES = 32;

    localparam logic [WORD_W-1:0] NOP = 32'h0;

    function automatic int index_w(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tag_w(input int lines);
        return ADDR_W - OFFSET_W - $clog2(lines);
    endfunction

    localparam int INDEX_W = index_w(DEF_LINES);
    localparam int TAG_W   = tag_w(DEF_LINES);

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage: asynchronous read by index, synchronous single-port write.
// Only the valid bits are reset; tag and data contents are don't-care until filled.
module icache_array
    import icache_pkg::*;
#(
    parameter int LINES     = 32,
    parameter int LINE_BITS = 256,
    parameter int IDX_W     = $clog2(LINES),
    parameter int TAG_BITS  = 32 - 5 - $clog2(LINES)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [IDX_W-1:0]     rd_idx,
    output logic                 rd_vld,
    output logic [TAG_BITS-1:0]  rd_tag,
    output logic [LINE_BITS-1:0] rd_dat,
    input  logic                 wr_en,
    input  logic [IDX_W-1:0]     wr_idx,
    input  logic [TAG_BITS-1:0]  wr_tag,
    input  logic [LINE_BITS-1:0] wr_dat
);

    logic [LINES-1:0]     valid_q;
    logic [TAG_BITS-1:0]  tag_q  [LINES];
    logic [LINE_BITS-1:0] data_q [LINES];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_dat;
        end
    end

    assign rd_vld = valid_q[rd_idx];
    assign rd_tag = tag_q[rd_idx];
    assign rd_dat = data_q[rd_idx];

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped read-only instruction cache: 0-cycle hit, stalls the PC on a miss
// while one 32-byte line is refilled over a req/ack handshake (min 3 stall cycles).
module icache_ctrl
    import icache_pkg::*;
#(
    parameter int LINES     = 32,
    parameter int LINE_BITS = 256
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_i,
    input  logic [31:0]          pc_i,
    output logic [31:0]          instr_o,
    output logic                 stall_o,
    output logic                 mem_req_o,
    output logic [31:0]          mem_addr_o,
    input  logic                 mem_ack_i,
    input  logic [LINE_BITS-1:0] mem_data_i
);

    localparam int IDX_W    = index_w(LINES);
    localparam int TAG_BITS = tag_w(LINES);
    localparam int IDX_LO   = OFFSET_W;
    localparam int TAG_LO   = OFFSET_W + IDX_W;

    state_t                state_q, state_d;
    logic [31:0]           line_addr_q, line_addr_d;
    logic [LINE_BITS-1:0]  fill_q;

    logic [IDX_W-1:0]      pc_idx;
    logic [TAG_BITS-1:0]   pc_tag;
    logic [WSEL_W-1:0]     pc_wsel;
    logic                  rd_vld;
    logic [TAG_BITS-1:0]   rd_tag;
    logic [LINE_BITS-1:0]  rd_dat;
    logic [WORDS-1:0][31:0] rd_words;
    logic                  hit;
    logic                  fill_en;
    logic                  unused_bits;

    assign pc_idx   = pc_i[TAG_LO-1:IDX_LO];
    assign pc_tag   = pc_i[31:TAG_LO];
    assign pc_wsel  = pc_i[OFFSET_W-1:2];
    assign rd_words = rd_dat;
    assign unused_bits = ^pc_i[1:0];

    icache_array #(
        .LINES     (LINES),
        .LINE_BITS (LINE_BITS),
        .IDX_W     (IDX_W),
        .TAG_BITS  (TAG_BITS)
    ) u_array (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .rd_idx (pc_idx),
        .rd_vld (rd_vld),
        .rd_tag (rd_tag),
        .rd_dat (rd_dat),
        .wr_en  (fill_en),
        .wr_idx (line_addr_q[TAG_LO-1:IDX_LO]),
        .wr_tag (line_addr_q[31:TAG_LO]),
        .wr_dat (fill_q)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            line_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            line_addr_q <= line_addr_d;
        end
    end

    // Refill buffer needs no reset: it is only consumed in FILL, after an ack loaded it.
    always_ff @(posedge clk_i) begin
        if (state_q == FETCH && mem_ack_i) begin
            fill_q <= mem_data_i;
        end
    end

    always_comb begin
        state_d     = state_q;
        line_addr_d = line_addr_q;
        hit         = 1'b0;
        stall_o     = 1'b0;
        instr_o     = NOP;
        mem_req_o   = 1'b0;
        fill_en     = 1'b0;
        case (state_q)
            IDLE: begin
                hit = req_i && rd_vld && (rd_tag == pc_tag);
                if (hit) begin
                    instr_o = rd_words[pc_wsel];
                end else if (req_i) begin
                    stall_o     = 1'b1;
                    state_d     = FETCH;
                    line_addr_d = {pc_i[31:OFFSET_W], {OFFSET_W{1'b0}}};
                end
            end
            FETCH: begin
                stall_o   = 1'b1;
                mem_req_o = 1'b1;
                if (mem_ack_i) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                stall_o = 1'b1;
                fill_en = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mem_addr_o = line_addr_q;

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed bench for icache_ctrl: cold miss, hits, conflict, idle, zero-wait, index wrap, reset mid-fetch.
module tb_icache_ctrl;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         req_i;
    logic [31:0]  pc_i;
    logic [31:0]  instr_o;
    logic         stall_o;
    logic         mem_req_o;
    logic [31:0]  mem_addr_o;
    logic         mem_ack_i;
    logic [255:0] mem_data_i;

    int errors = 0;
    int checks = 0;

    icache_ctrl #(.LINES(32), .LINE_BITS(256)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .req_i      (req_i),
        .pc_i       (pc_i),
        .instr_o    (instr_o),
        .stall_o    (stall_o),
        .mem_req_o  (mem_req_o),
        .mem_addr_o (mem_addr_o),
        .mem_ack_i  (mem_ack_i),
        .mem_data_i (mem_data_i)
    );

    always #5 clk_i = ~clk_i;

    // pc_i must hold across any clock edge at which the cache is stalling.
    logic [31:0] pc_prev;
    logic        stall_prev = 1'b0;
    always @(posedge clk_i) begin
        if (stall_prev && rst_i) begin
            assert (pc_i === pc_prev) else begin
                errors++;
                $error("FAIL pc_stable observed=%h expected=%h", pc_i, pc_prev);
            end
        end
        pc_prev    <= pc_i;
        stall_prev <= stall_o;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [255:0] make_line(input logic [31:0] base);
        logic [255:0] l;
        for (int w = 0; w < 8; w++) l[32*w +: 32] = base + w;
        return l;
    endfunction

    // Miss on pc, ack k cycles into FETCH with words base+w, then check the hit.
    task automatic refill(input string tag, input logic [31:0] pc, input logic [31:0] base,
                          input int k);
        int stalls;
        logic [31:0] line_addr;
        line_addr = {pc[31:5], 5'b0};
        req_i = 1'b1;
        pc_i  = pc;
        #1;
        chk({tag, "_miss_stall"}, {31'b0, stall_o}, 32'd1);
        chk({tag, "_miss_instr"}, instr_o, 32'h0);
        chk({tag, "_miss_noreq"}, {31'b0, mem_req_o}, 32'd0);
        stalls = 1;
        for (int i = 1; i <= k; i++) begin
            tick();
            if (stall_o) stalls++;
            chk({tag, "_fetch_req"}, {31'b0, mem_req_o}, 32'd1);
            chk({tag, "_fetch_addr"}, mem_addr_o, line_addr);
        end
        mem_ack_i  = 1'b1;
        mem_data_i = make_line(base);
        tick();
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
        #1;
        if (stall_o) stalls++;
        chk({tag, "_fill_req"}, {31'b0, mem_req_o}, 32'd0);
        tick();
        #1;
        chk({tag, "_hit_stall"}, {31'b0, stall_o}, 32'd0);
        chk({tag, "_hit_instr"}, instr_o, base + {29'b0, pc[4:2]});
        chk({tag, "_stall_cycles"}, stalls, k + 2);
    endtask

    task automatic hit_chk(input string tag, input logic [31:0] pc, input logic [31:0] exp);
        req_i = 1'b1;
        pc_i  = pc;
        #1;
        chk({tag, "_stall"}, {31'b0, stall_o}, 32'd0);
        chk({tag, "_instr"}, instr_o, exp);
        chk({tag, "_noreq"}, {31'b0, mem_req_o}, 32'd0);
        tick();
    endtask

    initial begin
        rst_i      = 1'b0;
        req_i      = 1'b0;
        pc_i       = 32'h0;
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
        tick();
        tick();
        chk("rst_mem_req", {31'b0, mem_req_o}, 32'd0);
        chk("rst_mem_addr", mem_addr_o, 32'h0);
        chk("rst_instr", instr_o, 32'h0);
        chk("rst_stall", {31'b0, stall_o}, 32'd0);
        rst_i = 1'b1;
        tick();

        // Cold miss and hits across the filled line
        refill("cold", 32'h0, 32'h1000, 3);
        tick();
        for (int w = 1; w < 8; w++) hit_chk("line_hit", 32'(w * 4), 32'h1000 + 32'(w));

        // Conflict on index 0, then refetch original line
        refill("conflict", 32'h400, 32'h2000, 2);
        tick();
        refill("refetch", 32'h0, 32'h1000, 2);
        tick();
        hit_chk("refetch_hit", 32'h8, 32'h1002);

        // Idle fetch and spurious ack
        req_i = 1'b0;
        pc_i  = 32'h800;
        #1;
        chk("idle_stall", {31'b0, stall_o}, 32'd0);
        chk("idle_instr", instr_o, 32'h0);
        chk("idle_noreq", {31'b0, mem_req_o}, 32'd0);
        mem_ack_i  = 1'b1;
        mem_data_i = make_line(32'hDEAD0000);
        tick();
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
        #1;
        chk("spur_noreq", {31'b0, mem_req_o}, 32'd0);
        chk("spur_stall", {31'b0, stall_o}, 32'd0);
        tick();
        hit_chk("spur_line0", 32'h0, 32'h1000);

        // Zero-wait ack on the last index
        refill("wrap", 32'h3E0, 32'h5000, 1);
        tick();
        hit_chk("wrap_hit", 32'h3FC, 32'h5007);
        hit_chk("wrap_line0", 32'h4, 32'h1001);

        // Reset mid-FETCH
        req_i = 1'b1;
        pc_i  = 32'h40;
        tick();
        #1;
        chk("rstf_req_before", {31'b0, mem_req_o}, 32'd1);
        rst_i = 1'b0;
        #1;
        chk("rstf_req_async", {31'b0, mem_req_o}, 32'd0);
        chk("rstf_addr", mem_addr_o, 32'h0);
        tick();
        req_i = 1'b0;
        rst_i = 1'b1;
        mem_ack_i  = 1'b1;
        mem_data_i = make_line(32'hBAD00000);
        tick();
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
        #1;
        chk("stale_ack_noreq", {31'b0, mem_req_o}, 32'd0);
        chk("stale_ack_stall", {31'b0, stall_o}, 32'd0);
        tick();
        refill("after_rst", 32'h40, 32'h3000, 2);
        tick();
        refill("line0_cleared", 32'h0, 32'h1000, 1);
        tick();

        req_i = 1'b0;
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/icache_ctrl.md
# icache_ctrl

Direct-mapped, read-only instruction cache sitting on the fetch side of the program counter register: it consumes the fetch address, returns the instruction word on a hit, and on a miss raises `stall_o` (which drives the PC's `stall_i` and the IF/ID register hold) while it refills one 256-bit line from instruction memory over a request/acknowledge handshake. It is the consumer end of the PC interface and the initiator on the instruction-memory interface.

## Interface
- `LINES`, 32: number of cache lines; power of two, ≥2.
- `LINE_BITS`, 256: line width; fixed at 8 × 32-bit words, 32-byte lines.
- `clk_i` in 1: clock.
- `rst_i` in 1: reset; asynchronous, active-low.
- `req_i` in 1: fetch enable (tied to the CPU start signal).
- `pc_i` in 32: fetch byte address from the PC register; bits [1:0] ignored.
- `instr_o` out 32: instruction word; valid when `req_i=1` and `stall_o=0`.
- `stall_o` out 1: 1 = instruction not available; the PC and IF/ID hold.
- `mem_req_o` out 1: line-fetch request to instruction memory.
- `mem_addr_o` out 32: line-aligned byte address, bits [4:0]=0.
- `mem_ack_i` in 1: one-cycle pulse; `mem_data_i` valid in the same cycle.
- `mem_data_i` in 256: refill line; word *w* = bits [32w+31:32w].

## Operation
- Address split: offset `pc_i[4:0]`, word select `pc_i[4:2]`, index `pc_i[4+log2(LINES):5]`, tag = remaining upper bits (22 bits at LINES=32).
- Storage: per line, one valid bit, tag, and 256-bit data. Reset clears all valid bits only.
- FSM states: IDLE, FETCH, FILL.
  - IDLE: hit = `req_i` & valid[index] & tag match. Hit: `instr_o` = selected word, `stall_o=0`. Miss with `req_i=1`: `stall_o=1`, next state FETCH, latch line address `{pc_i[31:5],5'b0}`.
  - FETCH: `mem_req_o=1`, `mem_addr_o` = latched address, both held stable until `mem_ack_i`. On ack: register `mem_data_i`, next state FILL.
  - FILL: write registered line, tag, and valid=1 at the latched index; next state IDLE.
- `stall_o` = (state≠IDLE) | (IDLE & `req_i` & miss); combinational.
- `req_i=0`: `stall_o=0`, `instr_o=0` (NOP), no miss is started.
- `instr_o=0` whenever `stall_o=1` or `req_i=0`.
- `mem_ack_i` outside FETCH is ignored.
- `pc_i` must be stable while `stall_o=1`; the bench asserts this. The cache uses the latched address, not `pc_i`, for the refill.
- A refill overwrites the indexed line unconditionally; there is no write path and no dirty state.

## Timing
- Reset values: state IDLE, all valid=0, `mem_req_o=0`, `mem_addr_o=0`, `instr_o=0`, `stall_o=0` while `req_i=0`.
- Hit latency: 0 cycles (combinational from `pc_i`).
- Miss detected in cycle T: `stall_o=1` in T. `mem_req_o=1` from T+1. Ack sampled in cycle T+k (k≥1). FILL at T+k+1. IDLE hit at T+k+2 with `stall_o=0`.
- Minimum miss penalty: 3 stall cycles (ack in the first FETCH cycle).
- Reset mid-FETCH or mid-FILL: `mem_req_o` drops asynchronously, the refill is abandoned, and that line stays invalid. A late ack after reset is ignored.

## Structure
- Package `icache_pkg`: state enum (IDLE/FETCH/FILL), localparams for offset, index, and tag widths derived from `LINES`, and the NOP constant 32'h0.
- Sub-module `icache_array`: valid/tag/data storage with asynchronous read by index, synchronous single-port write, and valid-clear on `rst_i`. The FSM, hit compare, and word mux live in `icache_ctrl`.

## Test plan
- Cold miss: reset, then `req_i=1`, `pc_i=0x0`, memory acks 3 cycles after request with words 0x1000+w → `stall_o=1` immediately; `mem_req_o=1`, `mem_addr_o=0x0` next cycle; `instr_o=0x1000`, `stall_o=0` two cycles after ack.
- Line hits: after the cold miss, `pc_i` = 0x4…0x1C → `instr_o` = 0x1001…0x1007, `stall_o=0`, `mem_req_o` never asserted.
- Conflict: `pc_i=0x400` (index 0, tag 1) → miss, `mem_addr_o=0x400`. Then `pc_i=0x0` → miss again and refetch from 0x0.
- Idle fetch: `req_i=0`, `pc_i=0x800` → `stall_o=0`, `instr_o=0`, no memory request. Spurious `mem_ack_i` pulse → no state change.
- Zero-wait ack: ack in the first FETCH cycle → exactly 3 stall cycles. Index wrap: `pc_i=0x3E0` (last index) fills and hits correctly.
- Reset mid-FETCH: drop `rst_i` while `mem_req_o=1` → `mem_req_o=0` immediately. After release, the same `pc_i` misses again (valid cleared), and the stale ack is ignored.
